// File: rtl/rvsteel_button_sequencer.sv
// Button front end for rvsteel_mcu: synchronizes and debounces the reset/halt buttons,
// sequences power-on and button resets with a minimum hold, and drives level or toggle halt.
module rvsteel_button_sequencer #(
  parameter int DEBOUNCE_CYCLES   = 120000,
  parameter int RESET_HOLD_CYCLES = 16,
  parameter bit HALT_TOGGLE       = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic reset_button,
  input  logic halt_button,
  output logic mcu_reset,
  output logic mcu_halt,
  output logic running
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_POR,
    ST_RUN,
    ST_HELD,
    ST_STRETCH
  } state_t;

  // Bit 0 is the reset button, bit 1 the halt button.
  logic [1:0] btn_raw;
  logic [1:0] db_level;

  assign btn_raw = {halt_button, reset_button};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_button
      logic            sync1_reg;
      logic            sync2_reg;
      logic            stable_reg;
      logic [DB_W-1:0] cnt_reg;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          sync1_reg  <= 1'b0;
          sync2_reg  <= 1'b0;
          stable_reg <= 1'b0;
          cnt_reg    <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == stable_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_LAST) begin
            stable_reg <= sync2_reg;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign db_level[gi] = stable_reg;
    end
  endgenerate

  logic rb_level;
  logic hb_level;
  logic hb_prev_reg;
  logic hb_rise;

  assign rb_level = db_level[0];
  assign hb_level = db_level[1];
  assign hb_rise  = hb_level & ~hb_prev_reg;

  state_t              state_reg, state_next;
  logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic                mcu_reset_reg, mcu_reset_next;
  logic                mcu_halt_reg, mcu_halt_next;
  logic                running_reg, running_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_POR;
      hold_cnt_reg  <= '0;
      mcu_reset_reg <= 1'b1;
      mcu_halt_reg  <= 1'b0;
      running_reg   <= 1'b0;
      hb_prev_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hold_cnt_reg  <= hold_cnt_next;
      mcu_reset_reg <= mcu_reset_next;
      mcu_halt_reg  <= mcu_halt_next;
      running_reg   <= running_next;
      hb_prev_reg   <= hb_level;
    end
  end

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    case (state_reg)
      ST_POR: begin
        if (hold_cnt_reg == HOLD_LAST) begin
          hold_cnt_next = '0;
          state_next    = rb_level ? ST_HELD : ST_RUN;
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      ST_RUN: begin
        hold_cnt_next = '0;
        if (rb_level) state_next = ST_HELD;
      end
      ST_HELD: begin
        hold_cnt_next = '0;
        if (!rb_level) state_next = ST_STRETCH;
      end
      ST_STRETCH: begin
        // A re-press restarts the whole hold on the next release.
        if (rb_level) begin
          hold_cnt_next = '0;
          state_next    = ST_HELD;
        end else if (hold_cnt_reg == HOLD_LAST) begin
          hold_cnt_next = '0;
          state_next    = ST_RUN;
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      default: begin
        hold_cnt_next = '0;
        state_next    = ST_POR;
      end
    endcase
  end

  // Halt only acts while staying in RUN; edges coinciding with entry or exit are dropped.
  always_comb begin
    mcu_halt_next = 1'b0;
    if (state_next == ST_RUN) begin
      if (HALT_TOGGLE != 1'b0) begin
        mcu_halt_next = mcu_halt_reg ^ ((state_reg == ST_RUN) && hb_rise);
      end else begin
        mcu_halt_next = hb_level;
      end
    end
    mcu_reset_next = (state_next != ST_RUN);
    running_next   = (state_next == ST_RUN) && !mcu_halt_next;
  end

  assign mcu_reset = mcu_reset_reg;
  assign mcu_halt  = mcu_halt_reg;
  assign running   = running_reg;

endmodule

// File: tb/tb_rvsteel_button_sequencer.sv
// Directed bench for rvsteel_button_sequencer with a level-halt and a toggle-halt instance
// sharing the same clock, reset and buttons (DEBOUNCE_CYCLES=8, RESET_HOLD_CYCLES=4).
module tb_rvsteel_button_sequencer;

  logic clock;
  logic reset;
  logic reset_button;
  logic halt_button;
  logic lvl_rst, lvl_halt, lvl_run;
  logic tog_rst, tog_halt, tog_run;

  int check_cnt = 0;
  int pass_cnt  = 0;

  rvsteel_button_sequencer #(
    .DEBOUNCE_CYCLES  (8),
    .RESET_HOLD_CYCLES(4),
    .HALT_TOGGLE      (1'b0)
  ) dut_lvl (
    .clock       (clock),
    .reset       (reset),
    .reset_button(reset_button),
    .halt_button (halt_button),
    .mcu_reset   (lvl_rst),
    .mcu_halt    (lvl_halt),
    .running     (lvl_run)
  );

  rvsteel_button_sequencer #(
    .DEBOUNCE_CYCLES  (8),
    .RESET_HOLD_CYCLES(4),
    .HALT_TOGGLE      (1'b1)
  ) dut_tog (
    .clock       (clock),
    .reset       (reset),
    .reset_button(reset_button),
    .halt_button (halt_button),
    .mcu_reset   (tog_rst),
    .mcu_halt    (tog_halt),
    .running     (tog_run)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Leaves time 1 unit after the n-th following rising edge.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  logic seen_high;

  initial begin
    reset        = 1'b0;
    reset_button = 1'b0;
    halt_button  = 1'b0;

    // Reset state
    ticks(3);
    check("rst_state_lvl_reset", lvl_rst, 1'b1);
    check("rst_state_lvl_halt", lvl_halt, 1'b0);
    check("rst_state_lvl_run", lvl_run, 1'b0);
    check("rst_state_tog_reset", tog_rst, 1'b1);

    // Power-on: mcu_reset falls on the 4th edge after deassertion
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      ticks(1);
      check("por_hold_reset", lvl_rst, 1'b1);
      check("por_hold_run", lvl_run, 1'b0);
    end
    ticks(1);
    check("por_done_reset", lvl_rst, 1'b0);
    check("por_done_run", lvl_run, 1'b1);
    check("por_done_halt", lvl_halt, 1'b0);
    check("por_done_tog_reset", tog_rst, 1'b0);
    ticks(5);

    // Reset press at edge k: mcu_reset rises at k+10
    reset_button = 1'b1;
    ticks(10);
    check("press_k9_reset", lvl_rst, 1'b0);
    ticks(1);
    check("press_k10_reset", lvl_rst, 1'b1);
    check("press_k10_run", lvl_run, 1'b0);
    ticks(20);
    // Release at edge m: mcu_reset falls at m+14
    reset_button = 1'b0;
    ticks(14);
    check("release_m13_reset", lvl_rst, 1'b1);
    ticks(1);
    check("release_m14_reset", lvl_rst, 1'b0);
    check("release_m14_run", lvl_run, 1'b1);
    ticks(5);

    // Glitch rejection: 7-cycle pulse, then a 3-cycle bounce for 40 cycles
    seen_high = 1'b0;
    reset_button = 1'b1;
    for (int i = 0; i < 7; i++) begin
      ticks(1);
      if (lvl_rst) seen_high = 1'b1;
    end
    reset_button = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ticks(1);
      if (lvl_rst) seen_high = 1'b1;
    end
    check("glitch_pulse_reset", seen_high, 1'b0);
    seen_high = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) reset_button = ~reset_button;
      ticks(1);
      if (lvl_rst) seen_high = 1'b1;
    end
    reset_button = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ticks(1);
      if (lvl_rst) seen_high = 1'b1;
    end
    check("glitch_bounce_reset", seen_high, 1'b0);
    check("glitch_bounce_run", lvl_run, 1'b1);

    // Toggle halt: three presses give 1, 0, 1
    halt_button = 1'b1;
    ticks(10);
    check("tog1_k9_halt", tog_halt, 1'b0);
    ticks(1);
    check("tog1_k10_halt", tog_halt, 1'b1);
    check("tog1_k10_run", tog_run, 1'b0);
    check("lvl_k10_halt", lvl_halt, 1'b1);
    ticks(9);
    halt_button = 1'b0;
    ticks(20);
    check("tog1_released_halt", tog_halt, 1'b1);
    check("lvl_released_halt", lvl_halt, 1'b0);

    halt_button = 1'b1;
    ticks(10);
    check("tog2_k9_halt", tog_halt, 1'b1);
    ticks(1);
    check("tog2_k10_halt", tog_halt, 1'b0);
    check("tog2_k10_run", tog_run, 1'b1);
    ticks(9);
    halt_button = 1'b0;
    ticks(20);

    halt_button = 1'b1;
    ticks(11);
    check("tog3_k10_halt", tog_halt, 1'b1);
    ticks(9);
    halt_button = 1'b0;
    ticks(20);
    check("tog3_released_halt", tog_halt, 1'b1);

    // A reset press clears the toggle state
    reset_button = 1'b1;
    ticks(11);
    check("tog_rstpress_reset", tog_rst, 1'b1);
    check("tog_rstpress_halt", tog_halt, 1'b0);
    ticks(20);
    reset_button = 1'b0;
    ticks(15);
    check("tog_after_stretch_reset", tog_rst, 1'b0);
    check("tog_after_stretch_halt", tog_halt, 1'b0);
    check("tog_after_stretch_run", tog_run, 1'b1);
    ticks(10);
    check("tog_later_halt", tog_halt, 1'b0);

    // Halt during reset: both held, release reset only
    reset_button = 1'b1;
    halt_button  = 1'b1;
    ticks(11);
    check("both_k10_reset", lvl_rst, 1'b1);
    check("both_k10_halt", lvl_halt, 1'b0);
    ticks(20);
    reset_button = 1'b0;
    ticks(14);
    check("both_m13_reset", lvl_rst, 1'b1);
    check("both_m13_halt", lvl_halt, 1'b0);
    ticks(1);
    check("both_run_reset", lvl_rst, 1'b0);
    check("both_run_halt", lvl_halt, 1'b1);
    check("both_run_running", lvl_run, 1'b0);
    check("both_run_tog_halt", tog_halt, 1'b0);
    check("both_run_tog_running", tog_run, 1'b1);

    // Async reset while running with halt asserted
    ticks(2);
    reset = 1'b0;
    #1;
    check("async_run_reset", lvl_rst, 1'b1);
    check("async_run_halt", lvl_halt, 1'b0);
    check("async_run_running", lvl_run, 1'b0);
    halt_button = 1'b0;
    ticks(2);
    reset = 1'b1;
    ticks(4);
    check("async_run_por_reset", lvl_rst, 1'b0);
    check("async_run_por_running", lvl_run, 1'b1);
    ticks(5);

    // Async reset two cycles into STRETCH
    reset_button = 1'b1;
    ticks(31);
    reset_button = 1'b0;
    ticks(13);
    check("stretch2_reset", lvl_rst, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("async_stretch_reset", lvl_rst, 1'b1);
    check("async_stretch_halt", lvl_halt, 1'b0);
    check("async_stretch_running", lvl_run, 1'b0);
    ticks(2);
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      ticks(1);
      check("repor_hold_reset", lvl_rst, 1'b1);
    end
    ticks(1);
    check("repor_done_reset", lvl_rst, 1'b0);
    check("repor_done_running", lvl_run, 1'b1);
    check("repor_done_tog_reset", tog_rst, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
